// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply / divide controller.
// A start (ctrl_MULT or ctrl_DIV) latches both operands as 33-bit magnitudes
// plus a result sign. The operation then runs 32 iteration cycles (shift-add
// for multiply, restoring division for divide) and pulses data_resultRDY.
// A new start always aborts and restarts. Divide-by-zero finishes immediately.
module multdiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic        r_neg;        // result sign: operand signs differ
    logic [63:0] r_acc;        // multiply partial product (magnitude)
    logic [63:0] r_mcand;      // multiplicand magnitude, shifted left each step
    logic [31:0] r_shift;      // multiplier (MUL) or dividend->quotient (DIV)
    logic [31:0] r_rem;        // restoring-division remainder, always < divisor
    logic [32:0] r_b_mag;      // divisor magnitude (2^31 needs bit 32 clear path)

    logic        w_start, w_div_zero, w_last;
    logic [32:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    logic [63:0] w_acc_step, w_prod;
    logic        w_mul_exc;
    logic [32:0] w_rem_sh;
    logic [31:0] w_rem_sub;
    logic        w_q_bit;
    logic [31:0] w_quo_step, w_quo;
    logic        w_div_exc;

    assign w_start    = ctrl_MULT | ctrl_DIV;
    // ctrl_MULT wins, so the zero-divisor shortcut applies to a pure divide only
    assign w_div_zero = ~ctrl_MULT & ctrl_DIV & (data_operandB == 32'd0);
    assign w_last     = (r_cnt == 6'd31);

    // 33-bit magnitudes so that |0x80000000| = 2^31 is representable
    assign w_a_ext = {data_operandA[31], data_operandA};
    assign w_b_ext = {data_operandB[31], data_operandB};
    assign w_a_mag = data_operandA[31] ? (~w_a_ext + 33'd1) : w_a_ext;
    assign w_b_mag = data_operandB[31] ? (~w_b_ext + 33'd1) : w_b_ext;

    // Multiply step and final signed product
    assign w_acc_step = r_shift[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod     = r_neg ? (64'd0 - w_acc_step) : w_acc_step;
    // Overflow when product is not a sign-extended 32-bit value
    assign w_mul_exc  = ~((&w_prod[63:31]) | ~(|w_prod[63:31]));

    // Restoring divide step: shift in next dividend bit, subtract if it fits
    assign w_rem_sh   = {r_rem, r_shift[31]};
    assign w_q_bit    = (w_rem_sh >= r_b_mag);
    // Difference is < divisor <= 2^31, so the low 32 bits are exact
    assign w_rem_sub  = w_rem_sh[31:0] - r_b_mag[31:0];
    assign w_quo_step = {r_shift[30:0], w_q_bit};
    assign w_quo      = r_neg ? (32'd0 - w_quo_step) : w_quo_step;
    // Only a positive 2^31 quotient (0x80000000 / -1) is unrepresentable
    assign w_div_exc  = ~r_neg & w_quo_step[31];

    // Next-state logic; a start overrides whatever state we are in
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_MUL:   if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_start)
            w_next = ctrl_MULT ? S_MUL : (w_div_zero ? S_DONE : S_DIV);
    end

    // State register plus registered handshake outputs derived from next state
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_next;
            data_resultRDY <= (w_next == S_DONE);
            busy           <= (w_next == S_MUL) || (w_next == S_DIV);
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt          <= 6'd0;
            r_neg          <= 1'b0;
            r_acc          <= 64'd0;
            r_mcand        <= 64'd0;
            r_shift        <= 32'd0;
            r_rem          <= 32'd0;
            r_b_mag        <= 33'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= 6'd0;
            r_neg   <= data_operandA[31] ^ data_operandB[31];
            r_b_mag <= w_b_mag;
            r_acc   <= 64'd0;
            r_rem   <= 32'd0;
            if (ctrl_MULT) begin
                r_mcand <= {31'd0, w_a_mag};
                r_shift <= w_b_mag[31:0];
            end else begin
                r_mcand <= 64'd0;
                r_shift <= w_a_mag[31:0];
            end
            if (w_div_zero) begin
                data_result    <= 32'd0;
                data_exception <= 1'b1;
            end
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc   <= w_acc_step;
                    r_mcand <= {r_mcand[62:0], 1'b0};
                    r_shift <= {1'b0, r_shift[31:1]};
                    r_cnt   <= r_cnt + 6'd1;
                    if (w_last) begin
                        data_result    <= w_prod[31:0];
                        data_exception <= w_mul_exc;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_q_bit ? w_rem_sub : w_rem_sh[31:0];
                    r_shift <= w_quo_step;
                    r_cnt   <= r_cnt + 6'd1;
                    if (w_last) begin
                        data_result    <= w_quo;
                        data_exception <= w_div_exc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: the stimulus side pushes the expected
// result (value, exception, RDY cycle) computed with plain signed arithmetic;
// a monitor checks RDY pulses, busy window and result hold every cycle.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          start;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] hold_res = 32'd0;
    logic        hold_exc = 1'b0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Reference: signed arithmetic straight from the operation definition
    function automatic exp_t model(bit is_mul, logic [31:0] a, logic [31:0] b, int s);
        exp_t   e;
        longint p;
        int     qt;
        e.start = s;
        e.due   = s + 33;
        if (is_mul) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(e.res)));
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.due = s + 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            qt    = $signed(a) / $signed(b);
            e.res = qt;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the sampling edge
    task automatic start_op(bit m, bit d, logic [31:0] a, logic [31:0] b);
        int s;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        s = cyc;
        @(posedge clock);
        q.delete();
        q.push_back(model(m, a, b, s));
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got %0d pending results, expected 0", q.size());
            q.delete();
        end
    endtask

    // Reset low across one edge; model state cleared at that edge
    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clock);
        q.delete();
        hold_res = 32'd0;
        hold_exc = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [6];
        c[0] = 32'd0; c[1] = 32'd1; c[2] = 32'hFFFF_FFFF;
        c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF; c[5] = 32'd2;
        if ($urandom_range(3) == 0) return c[$urandom_range(5)];
        if ($urandom_range(1) == 0) return $urandom_range(200) - 100;
        return $urandom;
    endfunction

    // Monitor: checks every falling edge once enabled
    initial begin
        bit exp_busy;
        wait (mon_en);
        forever begin
            @(negedge clock);
            exp_busy = (q.size() != 0) && (cyc > q[0].start) && (cyc < q[0].due);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy @%0d: got %b expected %b", cyc, busy, exp_busy);
            end
            if (data_resultRDY === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdy_unexpected @%0d: got rdy 1 expected 0", cyc);
                end else begin
                    checks += 3;
                    if (cyc != q[0].due) begin
                        errors++;
                        $display("FAIL rdy_cycle: got %0d expected %0d", cyc, q[0].due);
                    end
                    if (data_result !== q[0].res) begin
                        errors++;
                        $display("FAIL result @%0d: got %h expected %h", cyc, data_result, q[0].res);
                    end
                    if (data_exception !== q[0].exc) begin
                        errors++;
                        $display("FAIL exception @%0d: got %b expected %b", cyc, data_exception, q[0].exc);
                    end
                    hold_res = q[0].res;
                    hold_exc = q[0].exc;
                    void'(q.pop_front());
                end
            end else begin
                checks++;
                if (data_resultRDY !== 1'b0 || data_result !== hold_res || data_exception !== hold_exc) begin
                    errors++;
                    $display("FAIL hold @%0d: got rdy %b res %h exc %b expected rdy 0 res %h exc %b",
                             cyc, data_resultRDY, data_result, data_exception, hold_res, hold_exc);
                end
                if (q.size() != 0 && cyc >= q[0].due) begin
                    checks++;
                    errors++;
                    $display("FAIL rdy_missing @%0d: got rdy 0 expected 1", cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        wait_cycles(2);

        start_op(1, 0, 32'd7, -32'sd6);              wait_idle();
        start_op(1, 0, 32'h7FFF_FFFF, 32'd2);        wait_idle();
        start_op(0, 1, -32'sd7, 32'd2);              wait_idle();
        start_op(0, 1, 32'd100, 32'd0);              wait_idle();
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        start_op(1, 0, 32'h8000_0000, 32'd1);        wait_idle();
        start_op(0, 1, 32'h8000_0000, 32'd1);        wait_idle();

        // Abort: DIV started 10 cycles into a MUL
        start_op(1, 0, 32'd3, 32'd3);
        wait_cycles(9);
        start_op(0, 1, 32'd20, 32'd4);
        wait_idle();

        // Reset in cycle 15 of a MUL; then both starts high in the first cycle after reset
        start_op(1, 0, 32'd12345, 32'd678);
        wait_cycles(14);
        pulse_reset();
        start_op(1, 1, 32'd9, 32'd5);
        wait_idle();

        // Randomized ops with random gaps (gaps under 32 cycles abort)
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            bit m, d;
            a = pick();
            b = pick();
            m = $urandom_range(1);
            d = ~m | ($urandom_range(3) == 0);
            start_op(m, d, a, b);
            if ($urandom_range(4) == 0) wait_cycles($urandom_range(31));
            else if ($urandom_range(9) == 0) wait_cycles(32);
            else wait_idle();
        end
        wait_idle();
        wait_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-003 SHALL have port: ctrl_MULT  input  1  start signed multiply of latched operands.
REQ-004 SHALL have port: ctrl_DIV  input  1  start signed divide of latched operands.
REQ-005 SHALL have port: data_operandA  input  32  multiplicand / dividend, two's complement.
REQ-006 SHALL have port: data_operandB  input  32  multiplier / divisor, two's complement.
REQ-007 SHALL have port: data_result  output  32  low product word or quotient.
REQ-008 SHALL have port: data_exception  output  1  overflow or divide-by-zero flag for current result.
REQ-009 SHALL have port: data_resultRDY  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: busy  output  1  high while an operation is in progress.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, DONE; all state and outputs registered.
REQ-012 SHALL sample ctrl_MULT/ctrl_DIV every cycle in every state; on a high sample: latch both operands, clear 6-bit iteration counter, enter MUL or DIV.
REQ-013 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are high in the same cycle.
REQ-014 SHALL abort any in-progress operation and restart with new operands when a start is sampled while busy; no resultRDY for the aborted operation.
REQ-015 SHALL perform exactly 32 iteration cycles in MUL/DIV (counter 0..31), then enter DONE.
REQ-016 SHALL assert data_resultRDY for exactly one cycle, the 33rd cycle after the start-sample cycle (start in cycle 0 -> RDY in cycle 33); DONE returns to IDLE next cycle unless a new start is sampled.
REQ-017 SHALL compute MUL iteratively (shift-add on magnitudes, or Booth radix-2) into a 64-bit product; data_result = product[31:0].
REQ-018 SHALL set data_exception on MUL when product[63:31] is not all-equal, i.e. product is not the 32-bit value sign-extended to 64 bits.
REQ-019 SHALL compute DIV by restoring division on operand magnitudes, quotient truncated toward zero; quotient negated when operand signs differ; remainder not output.
REQ-020 SHALL handle divisor 0: no iteration, data_result=0, data_exception=1, data_resultRDY pulse in cycle 1 after start sample.
REQ-021 SHALL handle 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1, normal 33-cycle latency.
REQ-022 SHALL handle magnitude of 0x80000000 as unsigned 2^31 (33-bit internal magnitude paths) with no spurious exception.
REQ-023 SHALL hold data_result and data_exception stable from the RDY cycle until the next RDY cycle or reset.
REQ-024 SHALL drive busy high from the cycle after a start sample through the cycle before RDY; busy low in IDLE and DONE.
REQ-025 SHALL ignore operand input changes after the start-sample cycle.

Reset
REQ-026 SHALL, with reset low at a rising edge, force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0, overriding any simultaneous start.
REQ-027 SHALL abandon an in-progress operation on reset with no later RDY pulse.
REQ-028 SHALL accept a start in the first cycle after reset is released.

Verification
REQ-029 SHALL pass: MUL 7 x -6 -> cycle 33 RDY=1, result 0xFFFFFFD6 (-42), exception 0, busy high cycles 1-32.
REQ-030 SHALL pass: MUL 0x7FFFFFFF x 2 -> cycle 33 result 0xFFFFFFFE, exception 1.
REQ-031 SHALL pass: DIV -7 / 2 -> cycle 33 result 0xFFFFFFFD (-3), exception 0; DIV 100 / 0 -> cycle 1 RDY, result 0, exception 1.
REQ-032 SHALL pass: DIV 0x80000000 / -1 -> cycle 33 result 0x80000000, exception 1; MUL 0x80000000 x 1 -> result 0x80000000, exception 0.
REQ-033 SHALL pass: MUL 3 x 3 started, DIV 20 / 4 started at cycle 10 -> single RDY at cycle 43, result 5; no RDY at cycle 33.
REQ-034 SHALL pass: reset low at cycle 15 of MUL -> all outputs 0 next cycle, no RDY ever for that operation; ctrl_MULT and ctrl_DIV high together -> multiply result.
